e10_csr_bridge: RTL and testbench

Indirect-access bridge between the E2E management register file and the four 10GE MAC CSR slaves.
- Consumes the management command word (bit16 = write, bit17 = read, bits[15:0] = MAC CSR address), the write-data word and the port-select word.
- Issues exactly one Avalon-MM transaction per command to the selected MAC.
- Returns read data and status to the management read-back register.
- Sits directly downstream of the management register decode and upstream of the per-port MAC CSR interfaces.

---
 rtl/e10_csr_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_e10_csr_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e10_csr_bridge.sv
// e10_csr_bridge: indirect-access bridge from the management register file to
// the per-port 10GE MAC CSR slaves (Avalon-MM).
// A rising edge on cmd[16] (write) or cmd[17] (read) launches exactly one
// transaction on the port chosen by port_sel. Address, data and port are
// captured when the command is accepted. rdata keeps the last read result.
// Optional build macro: E10_CSR_BRIDGE_TIMEOUT_EN. When it is defined, a
// transaction that stalls for TIMEOUT_CYC cycles is aborted. The abort sets
// err and loads rdata with 32'hDEADBEEF.
module e10_csr_bridge #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int NUM_PORTS   = 4,
    parameter int TIMEOUT_CYC = 1024,
    localparam int SEL_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        pClk,
    input  logic                        pck_cp2af_softReset_n,
    input  logic [ADDR_W+1:0]           cmd,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [SEL_W-1:0]            port_sel,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic                        err,
    input  logic                        err_clr,
    output logic [ADDR_W-1:0]           avm_address,
    output logic [NUM_PORTS-1:0]        avm_read,
    output logic [NUM_PORTS-1:0]        avm_write,
    output logic [DATA_W-1:0]           avm_writedata,
    input  logic [NUM_PORTS-1:0]        avm_waitrequest,
    input  logic [NUM_PORTS*DATA_W-1:0] avm_readdata,
    input  logic [NUM_PORTS-1:0]        avm_readdatavalid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD      = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]           state;
    logic [1:0]           cmd_q;
    logic [SEL_W-1:0]     port_q;
    logic                 wr_edge;
    logic                 rd_edge;
    logic                 accept;
    logic                 reject;
    logic                 active;
    logic                 wait_sel;
    logic                 rdv_sel;
    logic [DATA_W-1:0]    rd_slice;
    logic [NUM_PORTS-1:0] port_onehot;
    logic                 completing;
    logic                 timeout_hit;
    logic                 abort;
    logic                 err_set;

    assign wr_edge = cmd[ADDR_W]   & ~cmd_q[0];
    assign rd_edge = cmd[ADDR_W+1] & ~cmd_q[1];
    assign active  = (state == S_WR) || (state == S_RD) || (state == S_RD_WAIT);

    // Only a lone write or read edge is accepted. Both edges together are a
    // malformed command. Any edge that arrives outside IDLE is dropped.
    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (state == S_IDLE) begin
            accept = wr_edge ^ rd_edge;
            reject = wr_edge & rd_edge;
        end else begin
            reject = wr_edge | rd_edge;
        end
    end

    // Select the handshake signals and the read-data slice of the captured port.
    always_comb begin
        wait_sel = 1'b0;
        rdv_sel  = 1'b0;
        rd_slice = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_q == SEL_W'(i)) begin
                wait_sel = avm_waitrequest[i];
                rdv_sel  = avm_readdatavalid[i];
                rd_slice = avm_readdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Build the one-hot strobe for the port being selected at accept time.
    always_comb begin
        port_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_sel == SEL_W'(i)) begin
                port_onehot[i] = 1'b1;
            end
        end
    end

    // Flag the normal end of a transaction so that a slave finishing on the
    // last allowed cycle still counts as a success rather than a timeout.
    always_comb begin
        completing = 1'b0;
        case (state)
            S_WR, S_RD: completing = ~wait_sel;
            S_RD_WAIT:  completing = rdv_sel;
            default:    completing = 1'b0;
        endcase
    end

`ifdef E10_CSR_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] tmo_cnt;

    assign timeout_hit = active && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count the cycles spent waiting on the slave. The count restarts from zero
    // each time the bridge returns to IDLE.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE) begin
            tmo_cnt <= '0;
        end else if (active) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign abort   = timeout_hit & ~completing;
    assign err_set = reject | abort;

    // Sticky error flag. A new error wins over a clear in the same cycle.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Transaction FSM. It captures the command on accept, drives the strobes
    // until the slave accepts them, and collects the read data.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            state         <= S_IDLE;
            cmd_q         <= '0;
            port_q        <= '0;
            busy          <= 1'b0;
            rdata         <= '0;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_read      <= '0;
            avm_write     <= '0;
        end else begin
            cmd_q <= cmd[ADDR_W+1:ADDR_W];
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        avm_address   <= cmd[ADDR_W-1:0];
                        avm_writedata <= wdata;
                        port_q        <= port_sel;
                        busy          <= 1'b1;
                        if (wr_edge) begin
                            avm_write <= port_onehot;
                            state     <= S_WR;
                        end else begin
                            avm_read <= port_onehot;
                            state    <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (completing) begin
                        avm_write <= '0;
                        state     <= S_DONE;
                    end else if (abort) begin
                        avm_write <= '0;
                        rdata     <= DATA_W'(32'hDEADBEEF);
                        state     <= S_DONE;
                    end
                end
                S_RD: begin
                    if (completing) begin
                        avm_read <= '0;
                        if (rdv_sel) begin
                            rdata <= rd_slice;
                            state <= S_DONE;
                        end else begin
                            state <= S_RD_WAIT;
                        end
                    end else if (abort) begin
                        avm_read <= '0;
                        rdata    <= DATA_W'(32'hDEADBEEF);
                        state    <= S_DONE;
                    end
                end
                S_RD_WAIT: begin
                    if (completing) begin
                        rdata <= rd_slice;
                        state <= S_DONE;
                    end else if (abort) begin
                        rdata <= DATA_W'(32'hDEADBEEF);
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    avm_read  <= '0;
                    avm_write <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e10_csr_bridge.sv
// tb_e10_csr_bridge: directed self-checking bench for e10_csr_bridge.
// Each scenario task drives the inputs on the falling clock edge and checks the
// outputs there, half a cycle away from the active rising edge.
module tb_e10_csr_bridge;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int NUM_PORTS = 4;

    logic                        pClk;
    logic                        pck_cp2af_softReset_n;
    logic [ADDR_W+1:0]           cmd;
    logic [DATA_W-1:0]           wdata;
    logic [1:0]                  port_sel;
    logic [DATA_W-1:0]           rdata;
    logic                        busy;
    logic                        err;
    logic                        err_clr;
    logic [ADDR_W-1:0]           avm_address;
    logic [NUM_PORTS-1:0]        avm_read;
    logic [NUM_PORTS-1:0]        avm_write;
    logic [DATA_W-1:0]           avm_writedata;
    logic [NUM_PORTS-1:0]        avm_waitrequest;
    logic [NUM_PORTS*DATA_W-1:0] avm_readdata;
    logic [NUM_PORTS-1:0]        avm_readdatavalid;

    int compared;
    int mismatched;

    e10_csr_bridge #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_PORTS   (NUM_PORTS),
        .TIMEOUT_CYC (16)
    ) dut (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (pck_cp2af_softReset_n),
        .cmd                   (cmd),
        .wdata                 (wdata),
        .port_sel              (port_sel),
        .rdata                 (rdata),
        .busy                  (busy),
        .err                   (err),
        .err_clr               (err_clr),
        .avm_address           (avm_address),
        .avm_read              (avm_read),
        .avm_write             (avm_write),
        .avm_writedata         (avm_writedata),
        .avm_waitrequest       (avm_waitrequest),
        .avm_readdata          (avm_readdata),
        .avm_readdatavalid     (avm_readdatavalid)
    );

    // Free-running management clock.
    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    task automatic test_reset();
        pck_cp2af_softReset_n = 1'b0;
        cmd = '0; wdata = '0; port_sel = '0; err_clr = 1'b0;
        avm_waitrequest = '0; avm_readdata = '0; avm_readdatavalid = '0;
        @(negedge pClk);
        @(negedge pClk);
        compared++;
        if ((rdata !== 32'h0) || (busy !== 1'b0) || (err !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL reset_status: rdata=%h busy=%b err=%b, required 0/0/0", rdata, busy, err);
        end
        compared++;
        if ((avm_read !== 4'b0) || (avm_write !== 4'b0) || (avm_address !== 16'h0) || (avm_writedata !== 32'h0)) begin
            mismatched++;
            $display("[TB] FAIL reset_avm: rd=%b wr=%b addr=%h wd=%h, required all 0", avm_read, avm_write, avm_address, avm_writedata);
        end
        pck_cp2af_softReset_n = 1'b1;
        @(negedge pClk);
    endtask

    task automatic test_write();
        int busy_cyc;
        int wr_cyc;
        busy_cyc = 0;
        wr_cyc = 0;
        port_sel = 2'd2;
        wdata = 32'h0000000A;
        avm_waitrequest = 4'b0000;
        cmd = 18'h13C00;
        for (int i = 1; i <= 6; i++) begin
            @(negedge pClk);
            if (busy === 1'b1) busy_cyc++;
            if (avm_write !== 4'b0000) begin
                wr_cyc++;
                compared++;
                if ((avm_write !== 4'b0100) || (avm_address !== 16'h3C00) || (avm_writedata !== 32'h0000000A)) begin
                    mismatched++;
                    $display("[TB] FAIL write_bus: wr=%b addr=%h wd=%h, required 0100/3c00/0000000a", avm_write, avm_address, avm_writedata);
                end
            end
            if (i == 1) cmd = '0;
        end
        compared++;
        if (wr_cyc !== 1) begin
            mismatched++;
            $display("[TB] FAIL write_strobe_len: %0d cycles, required 1", wr_cyc);
        end
        compared++;
        if (busy_cyc !== 2) begin
            mismatched++;
            $display("[TB] FAIL write_busy_len: %0d cycles, required 2", busy_cyc);
        end
        compared++;
        if ((err !== 1'b0) || (rdata !== 32'h0)) begin
            mismatched++;
            $display("[TB] FAIL write_side: err=%b rdata=%h, required 0/00000000", err, rdata);
        end
    endtask

    task automatic test_read_wait();
        int rd_cyc;
        rd_cyc = 0;
        port_sel = 2'd1;
        avm_waitrequest = 4'b0010;
        avm_readdatavalid = 4'b0000;
        avm_readdata = '0;
        cmd = 18'h20C02;
        for (int i = 1; i <= 10; i++) begin
            @(negedge pClk);
            if (avm_read !== 4'b0000) begin
                rd_cyc++;
                compared++;
                if ((avm_read !== 4'b0010) || (avm_address !== 16'h0C02)) begin
                    mismatched++;
                    $display("[TB] FAIL read_bus: rd=%b addr=%h, required 0010/0c02", avm_read, avm_address);
                end
            end
            if (i == 6) begin
                compared++;
                if (rdata !== 32'h0) begin
                    mismatched++;
                    $display("[TB] FAIL read_foreign_valid: rdata=%h, required 00000000", rdata);
                end
            end
            if (i == 7) begin
                compared++;
                if (rdata !== 32'h0000000A) begin
                    mismatched++;
                    $display("[TB] FAIL read_data_timing: rdata=%h, required 0000000a", rdata);
                end
            end
            if (i == 1) cmd = '0;
            if (i == 2) port_sel = 2'd3;
            if (i == 4) avm_waitrequest = 4'b0000;
            if (i == 5) begin
                avm_readdatavalid = 4'b0001;
                avm_readdata[0 +: DATA_W] = 32'h00000055;
            end
            if (i == 6) begin
                avm_readdatavalid = 4'b0010;
                avm_readdata[DATA_W +: DATA_W] = 32'h0000000A;
            end
            if (i == 7) avm_readdatavalid = 4'b0000;
        end
        compared++;
        if (rd_cyc !== 4) begin
            mismatched++;
            $display("[TB] FAIL read_strobe_len: %0d cycles, required 4", rd_cyc);
        end
        compared++;
        if ((rdata !== 32'h0000000A) || (busy !== 1'b0) || (err !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL read_final: rdata=%h busy=%b err=%b, required 0000000a/0/0", rdata, busy, err);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic prev;
        pulses = 0;
        prev = 1'b0;
        port_sel = 2'd0;
        avm_waitrequest = 4'b0001;
        avm_readdatavalid = 4'b0000;
        cmd = 18'h20010;
        for (int i = 1; i <= 8; i++) begin
            @(negedge pClk);
            if ((avm_read[0] === 1'b1) && !prev) pulses++;
            prev = avm_read[0];
            if (i == 3) begin
                compared++;
                if ((err !== 1'b1) || (busy !== 1'b1)) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_err_set: err=%b busy=%b, required 1/1", err, busy);
                end
            end
            if (i == 1) cmd = '0;
            if (i == 2) cmd = 18'h20020;
            if (i == 3) cmd = '0;
            if (i == 4) begin
                avm_waitrequest = 4'b0000;
                avm_readdatavalid = 4'b0001;
                avm_readdata[0 +: DATA_W] = 32'h00001234;
            end
            if (i == 5) avm_readdatavalid = 4'b0000;
        end
        compared++;
        if (pulses !== 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_pulses: %0d read pulses, required 1", pulses);
        end
        compared++;
        if ((rdata !== 32'h00001234) || (avm_address !== 16'h0010) || (err !== 1'b1) || (busy !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL b2b_final: rdata=%h addr=%h err=%b busy=%b, required 00001234/0010/1/0", rdata, avm_address, err, busy);
        end
        err_clr = 1'b1;
        @(negedge pClk);
        err_clr = 1'b0;
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_err_clr: err=%b, required 0", err);
        end
    endtask

    task automatic test_simultaneous();
        logic saw_activity;
        saw_activity = 1'b0;
        cmd = 18'h30000;
        err_clr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge pClk);
            if ((avm_read !== 4'b0) || (avm_write !== 4'b0) || (busy !== 1'b0)) saw_activity = 1'b1;
            if (i == 1) begin
                compared++;
                if (err !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL simul_err_set_wins: err=%b, required 1", err);
                end
                cmd = '0;
                err_clr = 1'b0;
            end
        end
        compared++;
        if (saw_activity !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL simul_no_txn: activity=%b, required 0", saw_activity);
        end
        compared++;
        if ((err !== 1'b1) || (rdata !== 32'h00001234)) begin
            mismatched++;
            $display("[TB] FAIL simul_sticky: err=%b rdata=%h, required 1/00001234", err, rdata);
        end
        err_clr = 1'b1;
        @(negedge pClk);
        err_clr = 1'b0;
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL simul_err_clr: err=%b, required 0", err);
        end
    endtask

    task automatic test_reset_mid_read();
        port_sel = 2'd2;
        avm_waitrequest = 4'b0000;
        avm_readdatavalid = 4'b0000;
        cmd = 18'h20005;
        @(negedge pClk);
        compared++;
        if (avm_read !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL rst_read_strobe: rd=%b, required 0100", avm_read);
        end
        cmd = '0;
        @(negedge pClk);
        compared++;
        if ((busy !== 1'b1) || (avm_read !== 4'b0000)) begin
            mismatched++;
            $display("[TB] FAIL rst_in_rd_wait: busy=%b rd=%b, required 1/0000", busy, avm_read);
        end
        #2;
        pck_cp2af_softReset_n = 1'b0;
        #1;
        compared++;
        if ((busy !== 1'b0) || (rdata !== 32'h0) || (avm_read !== 4'b0) || (avm_address !== 16'h0)) begin
            mismatched++;
            $display("[TB] FAIL rst_async: busy=%b rdata=%h rd=%b addr=%h, required 0/00000000/0000/0000", busy, rdata, avm_read, avm_address);
        end
        @(negedge pClk);
        pck_cp2af_softReset_n = 1'b1;
        @(negedge pClk);
        port_sel = 2'd3;
        avm_readdatavalid = 4'b1000;
        avm_readdata[3*DATA_W +: DATA_W] = 32'hCAFEF00D;
        cmd = 18'h20007;
        @(negedge pClk);
        cmd = '0;
        @(negedge pClk);
        avm_readdatavalid = 4'b0000;
        compared++;
        if (rdata !== 32'hCAFEF00D) begin
            mismatched++;
            $display("[TB] FAIL rst_new_read: rdata=%h, required cafef00d", rdata);
        end
        @(negedge pClk);
        compared++;
        if ((busy !== 1'b0) || (err !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL rst_new_read_done: busy=%b err=%b, required 0/0", busy, err);
        end
    endtask

`ifdef E10_CSR_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int wr_cyc;
        wr_cyc = 0;
        port_sel = 2'd0;
        avm_waitrequest = 4'b1111;
        cmd = 18'h10001;
        for (int i = 1; i <= 20; i++) begin
            @(negedge pClk);
            if (avm_write[0] === 1'b1) wr_cyc++;
            if (i == 1) cmd = '0;
        end
        avm_waitrequest = 4'b0000;
        compared++;
        if (wr_cyc !== 16) begin
            mismatched++;
            $display("[TB] FAIL timeout_strobe_len: %0d cycles, required 16", wr_cyc);
        end
        compared++;
        if ((err !== 1'b1) || (rdata !== 32'hDEADBEEF) || (busy !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL timeout_final: err=%b rdata=%h busy=%b, required 1/deadbeef/0", err, rdata, busy);
        end
    endtask
`endif

    // Scenario sequence followed by the single summary line.
    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid_read();
`ifdef E10_CSR_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
